// File: rtl/pipeline_cmd_issuer_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_cmd_issuer_if
// Brief    : Host byte link plus pipeline configuration port seen by the issuer.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_cmd_issuer_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int N_BLOCKS       = 256,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int INSTR_WIDTH    = 32
);
    localparam int c_BW = $clog2(N_BLOCKS);

    logic [7:0]                     in_byte;
    logic                           in_valid;
    logic                           in_ready;
    logic [c_BW-1:0]                block_target;
    logic [c_BW+REG_ADDR_WIDTH-1:0] reg_target;
    logic [INSTR_WIDTH-1:0]         instr_val;
    logic [DATA_WIDTH-1:0]          ctrl_data;
    logic [2*DATA_WIDTH-1:0]        buf_init_delay;
    logic                           instr_write;
    logic                           reg_write;
    logic                           reg_update;
    logic                           alloc_delay;
    logic                           reg_writes_commit;
    logic                           full_reset;
    logic                           instr_write_ack;
    logic                           reg_write_ack;
    logic                           resetting;
    logic                           busy;
    logic                           done;
    logic                           error;
    logic [1:0]                     err_code;
    logic [15:0]                    cmds_done;

    // Issuer side
    modport master (
        input  in_byte, in_valid, instr_write_ack, reg_write_ack, resetting,
        output in_ready, block_target, reg_target, instr_val, ctrl_data,
               buf_init_delay, instr_write, reg_write, reg_update, alloc_delay,
               reg_writes_commit, full_reset, busy, done, error, err_code, cmds_done
    );

    // Host link and pipeline side
    modport slave (
        output in_byte, in_valid, instr_write_ack, reg_write_ack, resetting,
        input  in_ready, block_target, reg_target, instr_val, ctrl_data,
               buf_init_delay, instr_write, reg_write, reg_update, alloc_delay,
               reg_writes_commit, full_reset, busy, done, error, err_code, cmds_done
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_cmd_issuer
// Brief    : Byte-stream command decoder driving the DSP pipeline config port.
//            Optional wait timeout enabled by CMD_ISSUER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_cmd_issuer #(
    parameter int DATA_WIDTH     = 16,
    parameter int N_BLOCKS       = 256,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int INSTR_WIDTH    = 32,
    parameter int ACK_TIMEOUT    = 1024
) (
    input  wire logic             clk,
    input  wire logic             reset,
    pipeline_cmd_issuer_if.master cfg
);
    localparam int c_BW  = $clog2(N_BLOCKS);
    localparam int c_RW  = c_BW + REG_ADDR_WIDTH;
    localparam int c_DW2 = 2 * DATA_WIDTH;
    localparam int c_DB  = DATA_WIDTH / 8;
    localparam int c_IB  = INSTR_WIDTH / 8;
    localparam int c_CW  = ($clog2(ACK_TIMEOUT + 1) < 2) ? 2 : $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_COLLECT  = 3'd1;
    localparam logic [2:0] c_ISSUE    = 3'd2;
    localparam logic [2:0] c_WAIT_ACK = 3'd3;
    localparam logic [2:0] c_WAIT_RST = 3'd4;
    localparam logic [2:0] c_DONE     = 3'd5;

    localparam logic [7:0] c_OP_INSTR  = 8'h01;
    localparam logic [7:0] c_OP_REG_WR = 8'h02;
    localparam logic [7:0] c_OP_REG_UP = 8'h03;
    localparam logic [7:0] c_OP_ALLOC  = 8'h04;
    localparam logic [7:0] c_OP_COMMIT = 8'h05;
    localparam logic [7:0] c_OP_RESET  = 8'h06;

    // Index of the final payload byte for each opcode
    function automatic logic [7:0] f_last_idx(input logic [7:0] op);
        case (op)
            c_OP_INSTR:              return 8'(c_IB);
            c_OP_REG_WR, c_OP_REG_UP: return 8'(1 + c_DB);
            c_OP_ALLOC:              return 8'(2 * c_DB - 1);
            default:                 return 8'd0;
        endcase
    endfunction

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [7:0]             r_op;
    logic [7:0]             r_idx;
    logic [c_CW-1:0]        r_cnt;
    logic [c_BW-1:0]        r_block;
    logic [c_RW-1:0]        r_reg_tgt;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0]  r_ctrl;
    logic [c_DW2-1:0]       r_delay;
    logic                   r_error;
    logic [1:0]             r_err_code;
    logic [15:0]            r_cmds;

    logic w_accept;
    logic w_op_ok;
    logic w_no_payload;
    logic w_needs_ack;
    logic w_ack;
    logic w_timeout;

    assign w_accept     = cfg.in_valid && cfg.in_ready;
    assign w_op_ok      = (cfg.in_byte >= c_OP_INSTR) && (cfg.in_byte <= c_OP_RESET);
    assign w_no_payload = (cfg.in_byte == c_OP_COMMIT) || (cfg.in_byte == c_OP_RESET);
    assign w_needs_ack  = (r_op == c_OP_INSTR) || (r_op == c_OP_REG_WR) || (r_op == c_OP_REG_UP);
    assign w_ack        = (r_op == c_OP_INSTR) ? cfg.instr_write_ack : cfg.reg_write_ack;

`ifdef CMD_ISSUER_TIMEOUT_EN
    assign w_timeout = (r_cnt == c_CW'(ACK_TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:     if (w_accept && w_op_ok) w_next = w_no_payload ? c_ISSUE : c_COLLECT;
            c_COLLECT:  if (w_accept && (r_idx == f_last_idx(r_op))) w_next = c_ISSUE;
            c_ISSUE: begin
                if (w_needs_ack)             w_next = w_ack ? c_DONE : c_WAIT_ACK;
                else if (r_op == c_OP_RESET) w_next = c_WAIT_RST;
                else                         w_next = c_DONE;
            end
            c_WAIT_ACK: begin
                if (w_ack)          w_next = c_DONE;
                else if (w_timeout) w_next = c_IDLE;
            end
            // r_cnt != 0 guarantees at least two cycles spent here
            c_WAIT_RST: begin
                if ((r_cnt != '0) && !cfg.resetting) w_next = c_DONE;
                else if (w_timeout)                  w_next = c_IDLE;
            end
            c_DONE:     w_next = c_IDLE;
            default:    w_next = c_IDLE;
        endcase
    end

    always_comb begin
        cfg.in_ready          = !reset && ((r_state == c_IDLE) || (r_state == c_COLLECT));
        cfg.instr_write       = 1'b0;
        cfg.reg_write         = 1'b0;
        cfg.reg_update        = 1'b0;
        cfg.alloc_delay       = 1'b0;
        cfg.reg_writes_commit = 1'b0;
        cfg.full_reset        = 1'b0;
        if (r_state == c_ISSUE) begin
            cfg.instr_write       = (r_op == c_OP_INSTR);
            cfg.reg_write         = (r_op == c_OP_REG_WR);
            cfg.reg_update        = (r_op == c_OP_REG_UP);
            cfg.alloc_delay       = (r_op == c_OP_ALLOC);
            cfg.reg_writes_commit = (r_op == c_OP_COMMIT);
            cfg.full_reset        = (r_op == c_OP_RESET);
        end
        cfg.busy = (r_state != c_IDLE);
        cfg.done = (r_state == c_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset || ((r_state != c_WAIT_ACK) && (r_state != c_WAIT_RST))) r_cnt <= '0;
        else if (r_cnt != '1)                                                r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= '0;
            r_idx      <= '0;
            r_block    <= '0;
            r_reg_tgt  <= '0;
            r_instr    <= '0;
            r_ctrl     <= '0;
            r_delay    <= '0;
            r_error    <= 1'b0;
            r_err_code <= 2'd0;
            r_cmds     <= '0;
        end else begin
            if ((r_state == c_IDLE) && w_accept) begin
                if (w_op_ok) begin
                    r_op  <= cfg.in_byte;
                    r_idx <= '0;
                end else begin
                    r_error    <= 1'b1;
                    r_err_code <= 2'd1;
                end
            end
            if ((r_state == c_COLLECT) && w_accept) begin
                r_idx <= r_idx + 8'd1;
                case (r_op)
                    c_OP_INSTR: begin
                        if (r_idx == 8'd0) r_block <= c_BW'(cfg.in_byte);
                        else               r_instr <= (r_instr << 8) | INSTR_WIDTH'(cfg.in_byte);
                    end
                    c_OP_REG_WR, c_OP_REG_UP: begin
                        if (r_idx == 8'd0)      r_reg_tgt[c_RW-1:REG_ADDR_WIDTH] <= c_BW'(cfg.in_byte);
                        else if (r_idx == 8'd1) r_reg_tgt[REG_ADDR_WIDTH-1:0]    <= REG_ADDR_WIDTH'(cfg.in_byte);
                        else                    r_ctrl <= (r_ctrl << 8) | DATA_WIDTH'(cfg.in_byte);
                    end
                    c_OP_ALLOC: r_delay <= (r_delay << 8) | c_DW2'(cfg.in_byte);
                    default: ;
                endcase
            end
            // Leaving a wait state straight to IDLE only happens on timeout
            if (((r_state == c_WAIT_ACK) || (r_state == c_WAIT_RST)) && (w_next == c_IDLE)) begin
                r_error    <= 1'b1;
                r_err_code <= (r_state == c_WAIT_ACK) ? 2'd2 : 2'd3;
            end
            if (r_state == c_DONE) r_cmds <= r_cmds + 16'd1;
        end
    end

    assign cfg.block_target   = r_block;
    assign cfg.reg_target     = r_reg_tgt;
    assign cfg.instr_val      = r_instr;
    assign cfg.ctrl_data      = r_ctrl;
    assign cfg.buf_init_delay = r_delay;
    assign cfg.error          = r_error;
    assign cfg.err_code       = r_err_code;
    assign cfg.cmds_done      = r_cmds;
endmodule
`default_nettype wire

// File: doc/pipeline_cmd_issuer.md
# pipeline_cmd_issuer

Byte-stream command decoder that drives the DSP pipeline's configuration port: instruction writes, register writes/updates, delay-buffer allocation, register-commit and full reset. It is the initiator side of that port: it sits between the host link (SPI/UART byte receiver) and the pipeline. It serialises one command at a time, holds the target fields stable and waits for the pipeline's acknowledges.

## Interface
Parameters:
- `data_width`, 16, sample/ctrl word width; must be a multiple of 8.
- `n_blocks`, 256, block count; `BW = $clog2(n_blocks)`.
- `reg_addr_width`, 4, per-block register index width.
- `instr_width`, 32, block instruction width; multiple of 8.
- `ack_timeout`, 1024, cycles to wait for an ack or for reset completion.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_byte` in 8: command stream byte.
- `in_valid` in 1: `in_byte` valid.
- `in_ready` out 1: byte accepted on `in_valid && in_ready`.
- `block_target` out BW: target block.
- `reg_target` out BW+reg_addr_width: `{block, reg_index}`.
- `instr_val` out instr_width: instruction word.
- `ctrl_data` out data_width: register value.
- `buf_init_delay` out 2*data_width: delay length.
- `instr_write`, `reg_write`, `reg_update`, `alloc_delay`, `reg_writes_commit`, `full_reset` out 1 each: one-cycle strobes.
- `instr_write_ack`, `reg_write_ack` in 1: pipeline acknowledges.
- `resetting` in 1: pipeline reset in progress.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse per completed command.
- `error` out 1: sticky until `reset`.
- `err_code` out 2: last error (1 bad opcode, 2 ack timeout, 3 reset timeout).
- `cmds_done` out 16: completed-command counter, wraps.

## Operation
Commands: opcode byte, then payload, with multi-byte fields MSB-first. Byte counts: `DB = data_width/8`, `IB = instr_width/8`.
- 0x01 INSTR: block(1), instr(IB). Strobe `instr_write`; wait `instr_write_ack`.
- 0x02 REG_WRITE: block(1), reg(1, low reg_addr_width bits used), value(DB). Strobe `reg_write`; wait `reg_write_ack`.
- 0x03 REG_UPDATE: same payload as 0x02. Strobe `reg_update`; wait `reg_write_ack`.
- 0x04 ALLOC: delay(2*DB). Strobe `alloc_delay`; no ack.
- 0x05 COMMIT: no payload. Strobe `reg_writes_commit`; no ack.
- 0x06 FULL_RESET: no payload. Strobe `full_reset`, then wait for `resetting` low.
- Any other opcode: byte consumed, `error`=1, `err_code`=1, stay IDLE, no `done`.

Block index bytes are truncated to BW bits.

FSM states and transitions:
- IDLE: `in_ready`=1. On opcode, go to COLLECT, or to ISSUE if the command has no payload.
- COLLECT: `in_ready`=1. Shift bytes into field registers; after the last byte, go to ISSUE.
- ISSUE: `in_ready`=0. Assert the strobe for exactly one cycle. Next state is WAIT_ACK, WAIT_RST, or DONE.
- WAIT_ACK: hold fields; on ack go to DONE.
- WAIT_RST: after at least 2 cycles in the state and `resetting`=0, go to DONE.
- DONE: `done`=1, `cmds_done`+1, go to IDLE.

Field rules:
- An ack asserted in the ISSUE cycle itself counts and skips WAIT_ACK (ISSUE→DONE).
- Outputs `block_target`, `reg_target`, `instr_val`, `ctrl_data`, `buf_init_delay` change only in COLLECT. They hold their value across IDLE and until the next command's payload.
- Acks arriving in IDLE/COLLECT are ignored.

## Timing
- Reset values: all strobes 0, `in_ready` 0 in the reset cycle then 1, all field outputs 0, `busy` 0, `done` 0, `error` 0, `err_code` 0, `cmds_done` 0.
- Latency from the last payload byte edge: strobe on the next cycle. `done` comes 2 cycles after that for no-ack commands; with an immediate ack, also 2 cycles.
- Reset mid-command: partial bytes are discarded, strobes drop at the next edge, and the FSM returns to IDLE.
- `error` does not block further commands.

## Configuration
- `CMD_ISSUER_TIMEOUT_EN` defined: a counter runs in WAIT_ACK/WAIT_RST.
  - Reaching `ack_timeout` cycles sets `error`=1 and `err_code`=2 (ack) or 3 (reset), and returns to IDLE without `done`.
- Undefined: no timeout; the FSM waits indefinitely, and `err_code` 2/3 never occur.

## Test plan
- Bytes 02 05 03 12 34, ack 3 cycles after `reg_write` → `reg_target`=0x053, `ctrl_data`=0x1234, single `reg_write` pulse, `done` once, `cmds_done`=1.
- Bytes 01 07 DE AD BE EF, ack in the strobe cycle → `instr_val`=0xDEADBEEF, `block_target`=7, `done` 2 cycles after the last byte, no WAIT_ACK.
- Bytes 04 00 00 01 F4 then 05 → `buf_init_delay`=500 with an `alloc_delay` pulse, then a `reg_writes_commit` pulse, `cmds_done`=2.
- Byte 0x7F → `error`=1, `err_code`=1, `in_ready` stays 1; a following 05 still completes.
- With TIMEOUT_EN, send 02 00 00 00 01 and never ack → after 1024 cycles `err_code`=2, IDLE, no `done`. In the same sequence, assert `reset` mid-payload → all outputs at reset values.
